// File: rtl/ppu_job_sequencer_pkg.sv
// Shared types and default sizing for the ppu job sequencer and its helpers.
package ppu_job_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_KICK,
    S_BURST,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ROWS    = 16;
  localparam int DEF_PSUM_W  = 384;
  localparam int DEF_OUT_W   = 128;
  localparam int DEF_TIMEOUT = 1023;

  // Index width that stays at least one bit wide for degenerate requester counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ppu_job_sequencer_if.sv
// Requester-side and ppu-side signal bundle of the job sequencer.
interface ppu_job_sequencer_if
  import ppu_job_sequencer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int OUT_W   = DEF_OUT_W
) ();

  localparam int IDW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*8-1:0]      req_scale;
  logic [NUM_REQ*8-1:0]      req_bias;
  logic [NUM_REQ-1:0]        gnt;
  logic                      row_valid;
  logic [NUM_REQ*PSUM_W-1:0] row_data;
  logic                      row_ready;
  logic                      ppu_valid;
  logic [PSUM_W-1:0]         ppu_psum;
  logic [7:0]                ppu_scale;
  logic [7:0]                ppu_bias;
  logic                      ppu_done;
  logic [OUT_W-1:0]          ppu_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [OUT_W-1:0]          resp_data;
  logic [IDW-1:0]            resp_id;
  logic                      resp_err;
  logic                      busy;

  modport slave (
    input  req, req_scale, req_bias, row_valid, row_data, ppu_done, ppu_data, resp_ready,
    output gnt, row_ready, ppu_valid, ppu_psum, ppu_scale, ppu_bias,
           resp_valid, resp_data, resp_id, resp_err, busy
  );

  modport master (
    output req, req_scale, req_bias, row_valid, row_data, ppu_done, ppu_data, resp_ready,
    input  gnt, row_ready, ppu_valid, ppu_psum, ppu_scale, ppu_bias,
           resp_valid, resp_data, resp_id, resp_err, busy
  );

endinterface

// File: rtl/ppu_job_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
  import ppu_job_sequencer_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] NV = (IW + 1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot = N'({req, req} >> ptr);
    any = |req;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    idx = sum[IW-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/ppu_job_sequencer.sv
// Shares one ppu among NUM_REQ tile producers: arbitrate, buffer a job's rows,
// burst them to the ppu, then return the result (or a timeout error) to the winner.
module ppu_job_sequencer
  import ppu_job_sequencer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ROWS    = DEF_ROWS,
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  ppu_job_sequencer_if.slave bus
);

  localparam int IDW = idx_w(NUM_REQ);
  localparam int CW  = $clog2(ROWS) + 1;
  localparam int AW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]  LAST_ROW = CW'(ROWS - 1);
  localparam logic [CW-1:0]  ROWS_C   = CW'(ROWS);
  localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  state_t              state;
  logic [NUM_REQ-1:0]  gnt;
  logic                row_ready;
  logic                ppu_valid;
  logic [PSUM_W-1:0]   ppu_psum;
  logic [7:0]          ppu_scale;
  logic [7:0]          ppu_bias;
  logic                resp_valid;
  logic [OUT_W-1:0]    resp_data;
  logic [IDW-1:0]      resp_id;
  logic                resp_err;
  logic                busy;
  logic [IDW-1:0]      ptr;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       timer;

  logic [PSUM_W-1:0]   row_buf [ROWS];

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDW-1:0]      arb_idx;
  logic                arb_any;
  logic [7:0]          win_scale;
  logic [7:0]          win_bias;
  logic [PSUM_W-1:0]   cur_row;
  logic                row_wr;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // resp_id doubles as the registered winner index while a job is in flight.
  assign win_scale = bus.req_scale[int'(arb_idx)*8 +: 8];
  assign win_bias  = bus.req_bias[int'(arb_idx)*8 +: 8];
  assign cur_row   = bus.row_data[int'(resp_id)*PSUM_W +: PSUM_W];
  assign row_wr    = (state == S_FILL) && bus.row_valid && row_ready;

  always_ff @(posedge clk) begin
    if (row_wr) row_buf[cnt[AW-1:0]] <= cur_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt        <= '0;
      row_ready  <= 1'b0;
      ppu_valid  <= 1'b0;
      ppu_psum   <= '0;
      ppu_scale  <= '0;
      ppu_bias   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      timer      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arb_any) begin
            gnt       <= arb_gnt;
            resp_id   <= arb_idx;
            ppu_scale <= win_scale;
            ppu_bias  <= win_bias;
            ptr       <= (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
            cnt       <= '0;
            row_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (row_wr) begin
            if (cnt == LAST_ROW) begin
              cnt       <= '0;
              row_ready <= 1'b0;
              ppu_valid <= 1'b1;
              state     <= S_KICK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        // Row 0 is preloaded here so the burst runs gap-free from the next cycle.
        S_KICK: begin
          ppu_valid <= 1'b0;
          ppu_psum  <= row_buf[0];
          cnt       <= CW'(1);
          state     <= S_BURST;
        end
        S_BURST: begin
          if (cnt == ROWS_C) begin
            ppu_psum <= '0;
            cnt      <= '0;
            timer    <= '0;
            state    <= S_WAIT;
          end else begin
            ppu_psum <= row_buf[cnt[AW-1:0]];
            cnt      <= cnt + 1'b1;
          end
        end
        // A done pulse on the expiry cycle still counts as success.
        S_WAIT: begin
          if (bus.ppu_done) begin
            resp_data  <= bus.ppu_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (timer == TMAX) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            gnt        <= '0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt;
  assign bus.row_ready  = row_ready;
  assign bus.ppu_valid  = ppu_valid;
  assign bus.ppu_psum   = ppu_psum;
  assign bus.ppu_scale  = ppu_scale;
  assign bus.ppu_bias   = ppu_bias;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_id    = resp_id;
  assign bus.resp_err   = resp_err;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_ppu_job_sequencer.sv
// Directed and randomized jobs against a queue-free reference of the
// round-robin / fill / burst / wait / response rules.
module tb_ppu_job_sequencer;

  localparam int NR   = 4;
  localparam int ROWS = 16;
  localparam int PW   = 384;
  localparam int OW   = 128;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ppu_job_sequencer_if #(.NUM_REQ(NR), .PSUM_W(PW), .OUT_W(OW)) bus ();

  ppu_job_sequencer #(
    .NUM_REQ (NR),
    .ROWS    (ROWS),
    .PSUM_W  (PW),
    .OUT_W   (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  logic [PW-1:0] rows_m  [NR][ROWS];
  logic [7:0]    scale_m [NR];
  logic [7:0]    bias_m  [NR];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_row();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [OW-1:0] rand_word();
    logic [OW-1:0] v;
    for (int i = 0; i < OW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_params();
    for (int i = 0; i < NR; i++) begin
      bus.req_scale[i*8 +: 8] = scale_m[i];
      bus.req_bias[i*8 +: 8]  = bias_m[i];
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NR; i++) begin
      scale_m[i] = 8'($urandom);
      bias_m[i]  = 8'($urandom);
      for (int r = 0; r < ROWS; r++) rows_m[i][r] = rand_row();
    end
    drive_params();
  endtask

  // Reference arbitration: scan requesters starting at the pointer, wrapping around.
  function automatic int model_pick(input logic [NR-1:0] r);
    logic [31:0] j;
    for (int k = 0; k < NR; k++) begin
      j = 32'((m_ptr + k) % NR);
      if (r[j[1:0]]) return int'(j);
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_gnt"},        bus.gnt, '0);
    check({name, "_row_ready"},  bus.row_ready, '0);
    check({name, "_ppu_valid"},  bus.ppu_valid, '0);
    check({name, "_ppu_psum"},   bus.ppu_psum, '0);
    check({name, "_ppu_scale"},  bus.ppu_scale, '0);
    check({name, "_ppu_bias"},   bus.ppu_bias, '0);
    check({name, "_resp_valid"}, bus.resp_valid, '0);
    check({name, "_resp_data"},  bus.resp_data, '0);
    check({name, "_resp_id"},    bus.resp_id, '0);
    check({name, "_resp_err"},   bus.resp_err, '0);
    check({name, "_busy"},       bus.busy, '0);
  endtask

  // One full job from the IDLE state. lat<0 or lat>TO means the ppu never answers in time.
  task automatic do_job(input string name, input logic [NR-1:0] req_v, input bit gaps,
                        input int lat, input int resp_delay, input bit drop_req,
                        input bit stale_done, input int abort_row,
                        input logic [OW-1:0] done_word, output int got_id);
    int            w;
    int            cycles;
    int            beats;
    int            k;
    int            exp_k;
    logic          rr;
    logic [NR-1:0] exp_gnt;
    logic [OW-1:0] exp_data;
    logic          exp_err;

    w       = model_pick(req_v);
    exp_gnt = NR'(1) << w;
    got_id  = -1;
    bus.req = req_v;

    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.gnt == '0 && cycles < 8);
    got_id = int'(bus.resp_id);
    check({name, "_grant_latency"}, cycles, 1);
    check({name, "_gnt"},       bus.gnt, exp_gnt);
    check({name, "_resp_id"},   bus.resp_id, w);
    check({name, "_busy"},      bus.busy, 1'b1);
    check({name, "_row_ready"}, bus.row_ready, 1'b1);
    check({name, "_scale"},     bus.ppu_scale, scale_m[w]);
    check({name, "_bias"},      bus.ppu_bias, bias_m[w]);
    m_ptr = (w + 1) % NR;
    if (drop_req) bus.req = '0;

    beats  = 0;
    cycles = 0;
    while (beats < ROWS && cycles < 4 * ROWS) begin
      bus.row_valid = gaps ? cycles[0] : 1'b1;
      bus.row_data[w*PW +: PW] = rows_m[w][beats];
      bus.ppu_done  = stale_done && (cycles == 3);
      bus.ppu_data  = ~done_word;
      rr = bus.row_ready;
      tick();
      cycles++;
      if (bus.row_valid && rr) beats++;
    end
    bus.row_valid = 1'b0;
    bus.ppu_done  = 1'b0;
    check({name, "_fill_cycles"}, cycles, gaps ? 2 * ROWS : ROWS);
    check({name, "_kick_valid"},  bus.ppu_valid, 1'b1);
    check({name, "_kick_psum"},   bus.ppu_psum, '0);
    check({name, "_kick_ready"},  bus.row_ready, 1'b0);

    for (int r = 0; r < ROWS; r++) begin
      tick();
      check($sformatf("%s_burst_row%0d", name, r), bus.ppu_psum, rows_m[w][r]);
      check($sformatf("%s_burst_valid%0d", name, r), bus.ppu_valid, 1'b0);
      if (r == abort_row) begin
        bus.req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        check_all_zero({name, "_abort"});
        tick();
        check({name, "_abort_idle_resp"}, bus.resp_valid, 1'b0);
        check({name, "_abort_idle_gnt"},  bus.gnt, '0);
        return;
      end
    end

    tick();
    check({name, "_wait_psum"},  bus.ppu_psum, '0);
    check({name, "_wait_busy"},  bus.busy, 1'b1);
    check({name, "_wait_scale"}, bus.ppu_scale, scale_m[w]);

    k = 0;
    while (!bus.resp_valid && k < 4 * TO + 8) begin
      bus.ppu_done = (k == lat);
      bus.ppu_data = (k == lat) ? done_word : ~done_word;
      tick();
      bus.ppu_done = 1'b0;
      k++;
    end
    if (lat >= 0 && lat <= TO) begin
      exp_k    = lat + 1;
      exp_data = done_word;
      exp_err  = 1'b0;
    end else begin
      exp_k    = TO + 1;
      exp_data = '0;
      exp_err  = 1'b1;
    end
    check({name, "_wait_cycles"}, k, exp_k);
    check({name, "_resp_valid"},  bus.resp_valid, 1'b1);
    check({name, "_resp_data"},   bus.resp_data, exp_data);
    check({name, "_resp_err"},    bus.resp_err, exp_err);
    check({name, "_resp_id2"},    bus.resp_id, w);

    bus.resp_ready = 1'b0;
    for (int i = 0; i < resp_delay; i++) begin
      tick();
      check({name, "_hold_valid"}, bus.resp_valid, 1'b1);
      check({name, "_hold_data"},  bus.resp_data, exp_data);
      check({name, "_hold_err"},   bus.resp_err, exp_err);
      check({name, "_hold_gnt"},   bus.gnt, exp_gnt);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({name, "_done_valid"}, bus.resp_valid, 1'b0);
    check({name, "_done_gnt"},   bus.gnt, '0);
    check({name, "_done_busy"},  bus.busy, 1'b0);
  endtask

  initial begin
    int            id;
    logic [NR-1:0] rq;

    bus.req        = '0;
    bus.req_scale  = '0;
    bus.req_bias   = '0;
    bus.row_valid  = 1'b0;
    bus.ppu_done   = 1'b0;
    bus.ppu_data   = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NR; i++) bus.row_data[i*PW +: PW] = rand_row();

    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle_no_req");

    // Fairness with all requesters held high.
    for (int j = 0; j < 8; j++) begin
      load_random();
      do_job("fair", 4'b1111, 1'b0, $urandom_range(0, 10), 0, 1'b0, 1'b0, -1, rand_word(), id);
      check($sformatf("fair_order%0d", j), id, j % NR);
    end

    // Single directed job: requester 1, unit rows.
    scale_m[1] = 8'd2;
    bias_m[1]  = 8'd1;
    for (int r = 0; r < ROWS; r++) rows_m[1][r] = {16{24'h000001}};
    drive_params();
    do_job("single", 4'b0010, 1'b0, 4, 0, 1'b0, 1'b0, -1, {16{8'hAB}}, id);

    load_random();
    do_job("gaps", 4'b0101, 1'b1, 2, 0, 1'b0, 1'b0, -1, rand_word(), id);

    load_random();
    do_job("timeout", 4'b1000, 1'b0, -1, 0, 1'b0, 1'b0, -1, rand_word(), id);
    load_random();
    do_job("expiry_done", 4'b0001, 1'b0, TO, 0, 1'b0, 1'b0, -1, rand_word(), id);
    load_random();
    do_job("late_done", 4'b0110, 1'b0, TO + 1, 0, 1'b0, 1'b0, -1, rand_word(), id);

    load_random();
    do_job("backpressure", 4'b1111, 1'b0, 3, 10, 1'b0, 1'b0, -1, rand_word(), id);

    load_random();
    do_job("stale_drop", 4'b1010, 1'b0, 5, 1, 1'b1, 1'b1, -1, rand_word(), id);

    load_random();
    do_job("abort", 4'b0100, 1'b0, 3, 0, 1'b0, 1'b0, 6, rand_word(), id);
    load_random();
    do_job("after_abort", 4'b1110, 1'b0, 1, 0, 1'b0, 1'b0, -1, rand_word(), id);

    for (int j = 0; j < 12; j++) begin
      load_random();
      rq = NR'($urandom_range(1, (1 << NR) - 1));
      do_job($sformatf("rand%0d", j), rq, 1'($urandom), $urandom_range(0, TO + 3),
             $urandom_range(0, 3), 1'($urandom), 1'($urandom), -1, rand_word(), id);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
